qdr_sram_responder: RTL

Synthesizable memory-side responder for the single-data-rate, burst-of-2 QDR user-pin protocol that the QDR controller drives. It accepts independent read and write commands, stores write bursts with byte enables in an internal array, and returns read bursts after a fixed latency with a valid strobe. It sits in the board-less loopback build in place of the external QDRII+ device, so the controller and traffic checker can run closed-loop on one FPGA.

---
 rtl/qdr_sram_pkg.sv | 31 +++
 rtl/qdr_sram_rd_pipe.sv | 43 ++++
 rtl/qdr_sram_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/qdr_sram_pkg.sv
// Shared types and helpers for the QDR SRAM responder: burst FSM states and byte-lane merge.
package qdr_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B0   = 2'd1,
    ST_B1   = 2'd2
  } qdr_state_e;

  // The merge operates on a fixed maximum width so one function serves any
  // parameterization; callers zero-extend in and slice the result back down.
  localparam int unsigned MERGE_MAX_W  = 256;
  localparam int unsigned MERGE_MAX_BW = 32;

  function automatic logic [MERGE_MAX_W-1:0] lane_merge(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_BW-1:0] bw_n,
    input int unsigned             lane_w
  );
    logic [MERGE_MAX_W-1:0] merged;
    int unsigned lane;
    merged = old_word;
    for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
      lane = i / lane_w;
      if ((lane < MERGE_MAX_BW) && !bw_n[lane[4:0]]) merged[i[7:0]] = new_word[i[7:0]];
    end
    return merged;
  endfunction

endpackage

// File: rtl/qdr_sram_rd_pipe.sv
// Delay line carrying {valid, data} for STAGES cycles with synchronous clear.
module qdr_sram_rd_pipe #(
  parameter int WIDTH  = 36,
  parameter int STAGES = 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic w_unused_ctl;
      assign w_unused_ctl = i_clk ^ i_clr;
      assign o_vld  = i_vld;
      assign o_data = i_data;
    end else begin : g_stages
      logic [STAGES-1:0] r_vld;
      logic [WIDTH-1:0]  r_data [STAGES];

      always_ff @(posedge i_clk) begin
        if (i_clr) begin
          r_vld <= '0;
          for (int s = 0; s < STAGES; s++) r_data[s] <= '0;
        end else begin
          r_vld[0]  <= i_vld;
          r_data[0] <= i_data;
          for (int s = 1; s < STAGES; s++) begin
            r_vld[s]  <= r_vld[s-1];
            r_data[s] <= r_data[s-1];
          end
        end
      end

      assign o_vld  = r_vld[STAGES-1];
      assign o_data = r_data[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/qdr_sram_responder.sv
// Memory-side responder for the burst-of-2 QDR user-pin protocol (loopback stand-in for the SRAM).
// Optional command counters are built when QDR_SRAM_STATS_EN is defined.
module qdr_sram_responder
  import qdr_sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 36,
  parameter int BW_WIDTH       = 4,
  parameter int ADDR_WIDTH     = 18,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int RD_LATENCY     = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  qdriip_w_n,
  input  logic                  qdriip_r_n,
  input  logic [ADDR_WIDTH-1:0] qdriip_sa,
  input  logic [DATA_WIDTH-1:0] qdriip_d,
  input  logic [BW_WIDTH-1:0]   qdriip_bw_n,
  output logic [DATA_WIDTH-1:0] qdriip_q,
  output logic                  qdriip_qvld,
  output logic                  proto_err,
  output logic [1:0]            o_wr_state,
  output logic [1:0]            o_rd_state
`ifdef QDR_SRAM_STATS_EN
  ,
  output logic [31:0]           wr_cmd_cnt,
  output logic [31:0]           rd_cmd_cnt
`endif
);

  localparam int unsigned LANE_W    = DATA_WIDTH / BW_WIDTH;
  localparam int          MEM_IDX_W = MEM_ADDR_WIDTH + 1;
  localparam int          MEM_DEPTH = 1 << MEM_IDX_W;

  // Handshake: each command pin is a one-cycle strobe sampled with qdriip_sa;
  // a strobe is accepted in IDLE or B1 and rejected (proto_err) in B0.

  qdr_state_e                r_wr_state, w_wr_next;
  logic                      w_wr_accept, w_wr_reject, w_wr_en;
  logic [MEM_ADDR_WIDTH-1:0] r_wr_sa;
  logic [MEM_IDX_W-1:0]      w_wr_idx;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_wr_state <= ST_IDLE;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_wr_accept) r_wr_sa <= qdriip_sa[MEM_ADDR_WIDTH-1:0];
    end
  end

  always_comb begin
    w_wr_next   = r_wr_state;
    w_wr_accept = 1'b0;
    w_wr_reject = 1'b0;
    case (r_wr_state)
      ST_IDLE: begin
        if (!qdriip_w_n) begin
          w_wr_next   = ST_B0;
          w_wr_accept = 1'b1;
        end
      end
      ST_B0: begin
        w_wr_next   = ST_B1;
        w_wr_reject = !qdriip_w_n;
      end
      ST_B1: begin
        if (!qdriip_w_n) begin
          w_wr_next   = ST_B0;
          w_wr_accept = 1'b1;
        end else begin
          w_wr_next = ST_IDLE;
        end
      end
      default: w_wr_next = ST_IDLE;
    endcase
  end

  // A burst interrupted by reset is abandoned: no beat commits during reset.
  assign w_wr_en  = ((r_wr_state == ST_B0) || (r_wr_state == ST_B1)) && sys_rst_n;
  assign w_wr_idx = {r_wr_sa, r_wr_state == ST_B1};

  qdr_state_e                r_rd_state, w_rd_next;
  logic                      w_rd_accept, w_rd_reject, w_rd_en;
  logic [MEM_ADDR_WIDTH-1:0] r_rd_sa;
  logic [MEM_IDX_W-1:0]      w_rd_idx;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rd_state <= ST_IDLE;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_rd_accept) r_rd_sa <= qdriip_sa[MEM_ADDR_WIDTH-1:0];
    end
  end

  always_comb begin
    w_rd_next   = r_rd_state;
    w_rd_accept = 1'b0;
    w_rd_reject = 1'b0;
    case (r_rd_state)
      ST_IDLE: begin
        if (!qdriip_r_n) begin
          w_rd_next   = ST_B0;
          w_rd_accept = 1'b1;
        end
      end
      ST_B0: begin
        w_rd_next   = ST_B1;
        w_rd_reject = !qdriip_r_n;
      end
      ST_B1: begin
        if (!qdriip_r_n) begin
          w_rd_next   = ST_B0;
          w_rd_accept = 1'b1;
        end else begin
          w_rd_next = ST_IDLE;
        end
      end
      default: w_rd_next = ST_IDLE;
    endcase
  end

  assign w_rd_en  = (r_rd_state == ST_B0) || (r_rd_state == ST_B1);
  assign w_rd_idx = {r_rd_sa, r_rd_state == ST_B1};

  assign o_wr_state = r_wr_state;
  assign o_rd_state = r_rd_state;

  // Simple dual-port array with per-lane write enables; contents survive reset.
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge sys_clk) begin
    if (w_wr_en) begin
      for (int l = 0; l < BW_WIDTH; l++) begin
        if (!qdriip_bw_n[l]) r_mem[w_wr_idx][l*LANE_W +: LANE_W] <= qdriip_d[l*LANE_W +: LANE_W];
      end
    end
  end

  logic [DATA_WIDTH-1:0] r_ram_q;
  logic                  r_fwd_hit;
  logic [DATA_WIDTH-1:0] r_fwd_d;
  logic [BW_WIDTH-1:0]   r_fwd_bw_n;
  logic                  r_rd_vld0;

  // The RAM port is read-first; a same-word write in the same cycle is merged
  // in afterwards so the read sees the new bytes.
  always_ff @(posedge sys_clk) begin
    if (w_rd_en) r_ram_q <= r_mem[w_rd_idx];
    r_fwd_hit  <= w_wr_en && w_rd_en && (w_wr_idx == w_rd_idx);
    r_fwd_d    <= qdriip_d;
    r_fwd_bw_n <= qdriip_bw_n;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_rd_vld0 <= 1'b0;
    else            r_rd_vld0 <= w_rd_en;
  end

  logic [MERGE_MAX_W-1:0] w_merge_ext;
  logic [DATA_WIDTH-1:0]  w_rd_word;

  assign w_merge_ext = lane_merge(MERGE_MAX_W'(r_ram_q), MERGE_MAX_W'(r_fwd_d),
                                  {{(MERGE_MAX_BW - BW_WIDTH){1'b1}}, r_fwd_bw_n}, LANE_W);
  assign w_rd_word   = r_fwd_hit ? w_merge_ext[DATA_WIDTH-1:0] : r_ram_q;

  logic                  w_pipe_vld;
  logic [DATA_WIDTH-1:0] w_pipe_data;

  qdr_sram_rd_pipe #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (RD_LATENCY - 2)
  ) u_rd_pipe (
    .i_clk  (sys_clk),
    .i_clr  (!sys_rst_n),
    .i_vld  (r_rd_vld0),
    .i_data (w_rd_word),
    .o_vld  (w_pipe_vld),
    .o_data (w_pipe_data)
  );

  assign qdriip_qvld = w_pipe_vld;
  assign qdriip_q    = w_pipe_vld ? w_pipe_data : '0;

  logic r_proto_err;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)                      r_proto_err <= 1'b0;
    else if (w_wr_reject || w_rd_reject) r_proto_err <= 1'b1;
  end

  assign proto_err = r_proto_err;

`ifdef QDR_SRAM_STATS_EN
  logic [31:0] r_wr_cnt, r_rd_cnt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr_accept) r_wr_cnt <= r_wr_cnt + 32'd1;
      if (w_rd_accept) r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  end

  assign wr_cmd_cnt = r_wr_cnt;
  assign rd_cmd_cnt = r_rd_cnt;
`endif

  // Upper address bits alias by design, and the merge is computed wider than the data.
  logic w_unused_bits;
  assign w_unused_bits = ^{qdriip_sa[ADDR_WIDTH-1:MEM_ADDR_WIDTH], w_merge_ext[MERGE_MAX_W-1:DATA_WIDTH]};

endmodule
